serial_adder_ctrl: RTL and testbench

//  Bit-serial add controller. Sequences one external 1-bit full adder (fadderbydecoder-style: x,y,z -> s,c)

---
 rtl/serial_adder_ctrl_if.sv | 52 +++++
 rtl/serial_adder_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/serial_adder_ctrl_if.sv
// rtl/serial_adder_ctrl_if.sv - requester-side handshake bundle for the bit-serial add controller
//
// Purpose:
//   Groups the request/response signals between a requester and
//   serial_adder_ctrl. The requester uses the master modport and the
//   controller uses the slave modport.
//
// Signals (WIDTH = operand/result width):
//   start        request, sampled by the controller only while idle
//   a, b [W]     operands, latched when a start is accepted
//   cin          carry-in, latched when a start is accepted
//   busy         controller is adding or presenting a result
//   done         one-cycle pulse, result valid
//   sum  [W]     result, held until the next accepted start
//   cout         final carry, held like sum
//   ovf          signed overflow (present only with SERIAL_ADDER_OVF_EN)
//
// Build option: SERIAL_ADDER_OVF_EN adds the ovf signal.

interface serial_adder_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout
`ifdef SERIAL_ADDER_OVF_EN
    , output ovf
`endif
  );

endinterface

// File: rtl/serial_adder_ctrl.sv
// rtl/serial_adder_ctrl.sv - bit-serial add controller sequencing an external 1-bit full adder
//
// Purpose:
//   Adds two WIDTH-bit operands plus a carry-in by driving one shared
//   external full-adder cell, LSB first, one bit per clock. Owns the
//   operand shift registers, the carry flop, the result register and the
//   start/busy/done handshake.
//
//   Sequence: IDLE -(start)-> ADD (exactly WIDTH cycles) -> DONE (1 cycle)
//   -> IDLE. {cout, sum} = a + b + cin, modulo 2^(WIDTH+1).
//
// Parameters:
//   WIDTH        operand/result width, 2..32
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   bus          serial_adder_ctrl_if.slave: start/a/b/cin in,
//                busy/done/sum/cout (and ovf) out
//   fa_x, fa_y   current A / B bit to the full adder (0 outside ADD)
//   fa_z         carry flop to the full adder (0 outside ADD)
//   fa_s, fa_c   sum / carry back from the full adder
//
// Build option: SERIAL_ADDER_OVF_EN adds a registered signed-overflow
//   flag (bus.ovf), updated together with sum/cout.

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_adder_ctrl_if.slave   bus,
  output logic                 fa_x,
  output logic                 fa_y,
  output logic                 fa_z,
  input  logic                 fa_s,
  input  logic                 fa_c
);

  // Enough bits to count 0..WIDTH-1.
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic             carry;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  // Decoded controls from the next-state logic.
  logic             load_ops;
  logic             add_step;
  logic             last_step;

  // ---------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // FSM next-state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    load_ops  = 1'b0;
    add_step  = 1'b0;
    last_step = 1'b0;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    fa_x      = 1'b0;
    fa_y      = 1'b0;
    fa_z      = 1'b0;

    unique case (state)
      S_IDLE: begin
        // start is only looked at here, so requests while busy are dropped.
        if (bus.start) begin
          load_ops  = 1'b1;
          state_nxt = S_ADD;
        end
      end

      S_ADD: begin
        bus.busy = 1'b1;
        add_step = 1'b1;
        // The FA is fed straight from flops, so fa_s/fa_c settle within
        // the cycle and are captured at the next edge.
        fa_x     = a_sr[0];
        fa_y     = b_sr[0];
        fa_z     = carry;
        if (count == LAST_BIT) begin
          last_step = 1'b1;
          state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        bus.busy  = 1'b1;
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: operand shift registers, carry flop, bit counter, result
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      if (load_ops) begin
        a_sr   <= bus.a;
        b_sr   <= bus.b;
        carry  <= bus.cin;
        sum_sr <= '0;
        count  <= '0;
      end else if (add_step) begin
        // Result bits enter at the MSB end; after WIDTH shifts bit 0 of
        // the operands has reached bit 0 of the result.
        a_sr   <= a_sr >> 1;
        b_sr   <= b_sr >> 1;
        sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
        carry  <= fa_c;
        count  <= count + CNT_W'(1);
        // The visible result is taken from the final shift directly so it
        // is valid in the DONE cycle and stays frozen through later ADDs.
        if (last_step) begin
          sum_q  <= {fa_s, sum_sr[WIDTH-1:1]};
          cout_q <= fa_c;
        end
      end
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

`ifdef SERIAL_ADDER_OVF_EN
  // During the last ADD cycle the carry flop holds the carry into the MSB;
  // signed overflow is that carry differing from the carry out of the MSB.
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (last_step) begin
      ovf_q <= carry ^ fa_c;
    end
  end

  assign bus.ovf = ovf_q;
`else
  // Without the overflow option there is no extra state to keep.
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb/tb_serial_adder_ctrl.sv - self-checking bench for serial_adder_ctrl with a reference full adder
//
// Purpose:
//   Drives directed and random add requests through the interface, models
//   the external full adder, and compares busy/done/sum/cout (and ovf),
//   the per-bit FA operand sequence and reset behaviour against plain
//   arithmetic computed in the bench.

module tb_serial_adder_ctrl;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  logic fa_x, fa_y, fa_z;
  logic fa_s, fa_c;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] model_sum  = '0;
  logic         model_cout = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
  logic         model_ovf  = 1'b0;
`endif

  serial_adder_ctrl_if #(.WIDTH(W)) bus ();

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .fa_x  (fa_x),
    .fa_y  (fa_y),
    .fa_z  (fa_z),
    .fa_s  (fa_s),
    .fa_c  (fa_c)
  );

  // Reference full adder cell.
  assign fa_s = fa_x ^ fa_y ^ fa_z;
  assign fa_c = (fa_x & fa_y) | (fa_x & fa_z) | (fa_y & fa_z);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One complete request. Sampling happens on falling edges; sample k is
  // taken in the cycle after rising edge k-1 (edge 0 accepts start).
  // With hold=1 start stays high until the controller is back in IDLE.
  // Operands are scrambled mid-operation to prove they are not re-latched.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tc, input bit hold);
    int     full;
    int     mask;
    int     cin_k;
    int     sgn;
    logic [W:0] exp;
    full = int'(ta) + int'(tb_v) + int'(tc);
    exp  = full[W:0];
    @(negedge clk);
    bus.a     = ta;
    bus.b     = tb_v;
    bus.cin   = tc;
    bus.start = 1'b1;
    for (int k = 1; k <= W + 3; k++) begin
      @(negedge clk);
      if (!hold || k >= W + 2) bus.start = 1'b0;
      if (k == 3) begin
        bus.a   = ~ta;
        bus.b   = ~tb_v;
        bus.cin = ~tc;
      end
      if (k <= W) begin
        mask  = (1 << (k - 1)) - 1;
        cin_k = ((int'(ta) & mask) + (int'(tb_v) & mask) + int'(tc)) >> (k - 1);
        check("busy_add", 32'(bus.busy), 32'd1);
        check("done_add", 32'(bus.done), 32'd0);
        check("fa_x", 32'(fa_x), 32'(ta[k-1]));
        check("fa_y", 32'(fa_y), 32'(tb_v[k-1]));
        check("fa_z", 32'(fa_z), 32'(cin_k & 1));
        check("sum_hold", 32'(bus.sum), 32'(model_sum));
        check("cout_hold", 32'(bus.cout), 32'(model_cout));
      end else if (k == W + 1) begin
        model_sum  = exp[W-1:0];
        model_cout = exp[W];
        check("done_pulse", 32'(bus.done), 32'd1);
        check("busy_done", 32'(bus.busy), 32'd1);
        check("sum", 32'(bus.sum), 32'(model_sum));
        check("cout", 32'(bus.cout), 32'(model_cout));
        check("fa_x_done", 32'(fa_x), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        sgn = int'($signed(ta)) + int'($signed(tb_v)) + int'(tc);
        model_ovf = (sgn > 127 || sgn < -128);
        check("ovf", 32'(bus.ovf), 32'(model_ovf));
`else
        sgn = 0;
`endif
      end else begin
        check("done_idle", 32'(bus.done), 32'd0);
        check("busy_idle", 32'(bus.busy), 32'd0);
        check("fa_xyz_idle", {29'd0, fa_x, fa_y, fa_z}, 32'd0);
        check("sum_idle", 32'(bus.sum), 32'(model_sum));
      end
    end
  endtask

  // Reset asserted during the 4th ADD cycle must abort without a done.
  task automatic reset_mid_op();
    bit seen_done;
    seen_done = 1'b0;
    @(negedge clk);
    bus.a     = 8'h3C;
    bus.b     = 8'h5A;
    bus.cin   = 1'b1;
    bus.start = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_cout", 32'(bus.cout), 32'd0);
    model_sum  = '0;
    model_cout = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
    check("rst_ovf", 32'(bus.ovf), 32'd0);
    model_ovf = 1'b0;
`endif
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (bus.done) seen_done = 1'b1;
    end
    check("rst_no_done", 32'(seen_done), 32'd0);
    check("rst_idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_sum", 32'(bus.sum), 32'd0);
    check("reset_cout", 32'(bus.cout), 32'd0);
    check("reset_fa", {29'd0, fa_x, fa_y, fa_z}, 32'd0);
    rst_n = 1'b1;

    do_op(8'h05, 8'h03, 1'b0, 1'b0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0);
    do_op(8'hFF, 8'hFF, 1'b1, 1'b0);
    do_op(8'hA5, 8'h5A, 1'b0, 1'b0);
    do_op(8'h96, 8'h3C, 1'b1, 1'b1);
    reset_mid_op();
    do_op(8'h12, 8'h34, 1'b1, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0);
    do_op(8'h80, 8'h80, 1'b0, 1'b0);
    do_op(8'h00, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
